// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions for the memory arbiter: FSM states, owner
// encoding, busy-counter width and the grant selection helper.
package mem_arbiter_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // On a tie the requester that was not served last wins; a lone request
    // always wins.
    function automatic owner_e pick_owner(input logic i_req,
                                          input logic d_req,
                                          input owner_e last_grant);
        if (i_req && d_req) begin
            return (last_grant == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (d_req) begin
            return OWNER_D;
        end
        return OWNER_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_mux2.sv
// Two-input selector used to steer the latched fetch/data registers onto
// the memory bus.
module Mux2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (I) and data (D)
// requesters. One transaction at a time: grant, hold the bus until the
// memory answers or the busy counter times out, then pulse the owner's ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_cen,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [31:0]      NO_WDATA    = '0;

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      i_addr_q, i_addr_d;
    logic [31:0]      d_addr_q, d_addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wen_q, wen_d;
    logic             cen_q, cen_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             i_ack_q, i_ack_d;
    logic             d_ack_q, d_ack_d;
    logic             err_q, err_d;
    logic             finish;

    // Next-state logic: grant in IDLE, wait for ready or timeout in BUSY,
    // pulse the owner's ack in DONE.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        i_addr_d     = i_addr_q;
        d_addr_d     = d_addr_q;
        wdata_d      = wdata_q;
        wen_d        = wen_q;
        cen_d        = cen_q;
        rdata_d      = rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        finish       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = pick_owner(i_req, d_req, last_grant_q);
                    cnt_d   = '0;
                    cen_d   = 1'b1;
                    if (owner_d == OWNER_D) begin
                        state_d  = ST_D_BUSY;
                        d_addr_d = d_addr;
                        wdata_d  = d_wdata;
                        wen_d    = d_wen;
                    end else begin
                        state_d  = ST_I_BUSY;
                        i_addr_d = i_addr;
                        wen_d    = 1'b0;
                    end
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    finish  = 1'b1;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (finish) begin
                    state_d      = ST_DONE;
                    last_grant_d = owner_q;
                    cen_d        = 1'b0;
                    wen_d        = 1'b0;
                    i_ack_d      = (owner_q == OWNER_I);
                    d_ack_d      = (owner_q == OWNER_D);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_I;
            last_grant_q <= OWNER_I;
            cnt_q        <= '0;
            i_addr_q     <= '0;
            d_addr_q     <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            cen_q        <= 1'b0;
            rdata_q      <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            i_addr_q     <= i_addr_d;
            d_addr_q     <= d_addr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            cen_q        <= cen_d;
            rdata_q      <= rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
        end
    end

    Mux2 #(.W(32)) u_addr_mux (
        .in0 (i_addr_q),
        .in1 (d_addr_q),
        .sel (owner_q == OWNER_D),
        .out (mem_addr)
    );

    Mux2 #(.W(32)) u_wdata_mux (
        .in0 (NO_WDATA),
        .in1 (wdata_q),
        .sel (owner_q == OWNER_D),
        .out (mem_wdata)
    );

    assign mem_cen = cen_q;
    assign mem_wen = wen_q;
    assign rdata   = rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected ack, a
// negedge monitor pops and compares whenever an ack appears.
module tb_mem_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wen;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, err;
    logic [31:0] rdata;
    logic        mem_cen, mem_wen, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic        isD;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ackSeen = 0;
    int   memLat = 0;
    int   busyCycles = 0;
    logic modelReady = 1'b0;
    logic strayReady = 1'b0;

    assign mem_ready = modelReady | strayReady;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .rdata     (rdata),
        .err       (err),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // Cycle k is the period that starts at rising edge k.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] lookup(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ~a;
    endfunction

    // Memory model: answers in the memLat-th enabled cycle (0 = never).
    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_cen) begin
                busyCycles++;
                modelReady = (memLat != 0 && busyCycles == memLat);
                mem_rdata  = modelReady ? lookup(mem_addr) : 32'h0BAD_0BAD;
            end else begin
                busyCycles = 0;
                modelReady = 1'b0;
                mem_rdata  = '0;
            end
        end
    end

    // Monitor: every ack must match the oldest expected transaction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (i_ack || d_ack)) begin
            ackSeen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_ack: cyc=%0d i_ack=%b d_ack=%b err=%b rdata=%h, none required",
                         cyc, i_ack, d_ack, err, rdata);
            end else begin
                e = sb.pop_front();
                if ({i_ack, d_ack, err, rdata} !== {!e.isD, e.isD, e.err, e.rdata} || cyc != e.cyc) begin
                    errors++;
                    $display("[TB] FAIL ack: got cyc=%0d i_ack=%b d_ack=%b err=%b rdata=%h, required cyc=%0d i_ack=%b d_ack=%b err=%b rdata=%h",
                             cyc, i_ack, d_ack, err, rdata, e.cyc, !e.isD, e.isD, e.err, e.rdata);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    // Issue one request in the next cycle and queue its expected ack.
    task automatic applyStimulus(input logic isD, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int lat, input logic expErr,
                                 input logic [31:0] expRdata, output int c);
        exp_t e;
        @(posedge clk);
        #1;
        c = cyc;
        memLat = lat;
        if (isD) begin
            d_req = 1'b1; d_wen = wen; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        e.isD   = isD;
        e.err   = expErr;
        e.rdata = expRdata;
        e.cyc   = c + 1 + (expErr ? TIMEOUT + 1 : lat);
        sb.push_back(e);
    endtask

    task automatic waitAcks(input int target, input int budget, input string name);
        int n = 0;
        while (ackSeen < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (ackSeen < target) begin
            errors++;
            $display("[TB] FAIL %s: got %0d acks required %0d", name, ackSeen, target);
        end
    endtask

    // Wait for the ack in the DONE cycle and release the request there.
    task automatic finishTxn(input int target, input string name);
        waitAcks(target, 20, name);
        i_req = 1'b0;
        d_req = 1'b0;
        d_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int base;
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_cen", 32'(mem_cen), 32'd0);
        checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_acks_err", {29'd0, i_ack, d_ack, err}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // Fetch at 0x100, memory answers in cycle 3, ack in cycle 4
        base = ackSeen;
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, c);
        @(negedge clk);
        checkOutput("fetch_idle_cen", 32'(mem_cen), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("fetch_busy_cen", 32'(mem_cen), 32'd1);
            checkOutput("fetch_busy_addr", mem_addr, 32'h100);
            checkOutput("fetch_busy_wen", 32'(mem_wen), 32'd0);
        end
        finishTxn(base + 1, "fetch_ack_wait");

        // Store at 0x200; request inputs change mid-transaction
        base = ackSeen;
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h1234_5678, 2, 1'b0, 32'hFFFF_FDFF, c);
        @(negedge clk);
        @(posedge clk);
        #1;
        d_addr = 32'h300; d_wdata = 32'hCAFE_F00D; d_wen = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checkOutput("store_busy_wen", 32'(mem_wen), 32'd1);
            checkOutput("store_busy_addr", mem_addr, 32'h200);
            checkOutput("store_busy_wdata", mem_wdata, 32'h1234_5678);
        end
        finishTxn(base + 1, "store_ack_wait");

        // Ready arrives in the very cycle the counter hits TIMEOUT: no error
        base = ackSeen;
        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, TIMEOUT + 1, 1'b0, 32'hFFFF_FFBF, c);
        finishTxn(base + 1, "edge_ready_ack_wait");

        // Memory never answers: error ack in cycle TIMEOUT+2 with rdata 0
        base = ackSeen;
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 0, 1'b1, 32'h0, c);
        finishTxn(base + 1, "timeout_ack_wait");

        // Next request after a timeout proceeds normally
        base = ackSeen;
        applyStimulus(1'b1, 1'b0, 32'h84, 32'h0, 1, 1'b0, 32'hFFFF_FF7B, c);
        finishTxn(base + 1, "post_timeout_ack_wait");

        // Stray mem_ready while idle is ignored
        base = ackSeen;
        @(posedge clk);
        #1;
        strayReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        strayReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("stray_ready_no_ack", 32'(ackSeen), 32'(base));
        checkOutput("stray_ready_rdata", rdata, 32'hFFFF_FF7B);

        // Reset during D_BUSY drops the transaction
        @(posedge clk);
        #1;
        memLat = 0;
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h500; d_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre_rst_cen", 32'(mem_cen), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_cen_wen", {30'd0, mem_cen, mem_wen}, 32'd0);
        checkOutput("mid_rst_addr", mem_addr, 32'd0);
        checkOutput("mid_rst_wdata", mem_wdata, 32'd0);
        checkOutput("mid_rst_rdata", rdata, 32'd0);
        checkOutput("mid_rst_acks_err", {29'd0, i_ack, d_ack, err}, 32'd0);
        d_req = 1'b0; d_wen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = ackSeen;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("no_ack_after_rst", 32'(ackSeen), 32'(base));

        // Both requesting from reset: D, I, D, I
        @(posedge clk);
        #1;
        c = cyc;
        memLat = 1;
        i_addr = 32'h10; d_addr = 32'h20; d_wen = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        sb.push_back('{isD: 1'b1, err: 1'b0, rdata: 32'hFFFF_FFDF, cyc: c + 2});
        sb.push_back('{isD: 1'b0, err: 1'b0, rdata: 32'hFFFF_FFEF, cyc: c + 5});
        sb.push_back('{isD: 1'b1, err: 1'b0, rdata: 32'hFFFF_FFDF, cyc: c + 8});
        sb.push_back('{isD: 1'b0, err: 1'b0, rdata: 32'hFFFF_FFEF, cyc: c + 11});
        base = ackSeen;
        waitAcks(base + 4, 40, "alternate_ack_wait");
        i_req = 1'b0; d_req = 1'b0;

        repeat (4) @(negedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum busy cycles before abort (1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_req  input  1  fetch request, held until i_ack.
REQ-005 SHALL have port i_addr  input  32  fetch address.
REQ-006 SHALL have port i_ack  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port d_req  input  1  data request, held until d_ack.
REQ-008 SHALL have port d_wen  input  1  data request is a store (1) or load (0).
REQ-009 SHALL have port d_addr  input  32  data address.
REQ-010 SHALL have port d_wdata  input  32  store data.
REQ-011 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-012 SHALL have port rdata  output  32  captured read data, valid in the cycle i_ack or d_ack is high.
REQ-013 SHALL have port err  output  1  high together with an ack when that transaction timed out.
REQ-014 SHALL have port mem_cen  output  1  memory access enable.
REQ-015 SHALL have port mem_wen  output  1  memory write enable.
REQ-016 SHALL have port mem_addr  output  32  memory address.
REQ-017 SHALL have port mem_wdata  output  32  memory write data.
REQ-018 SHALL have port mem_rdata  input  32  memory read data, valid when mem_ready is high.
REQ-019 SHALL have port mem_ready  input  1  memory completion strobe.

Function
REQ-020 SHALL implement FSM IDLE, I_BUSY, D_BUSY, DONE.
REQ-021 SHALL, in IDLE with a single request, move to that requester's BUSY state at the next edge.
REQ-022 SHALL, in IDLE with both requests, grant the requester not served last (last_grant bit, reset to I, so D wins the first tie).
REQ-023 SHALL latch the owner, address, wen and wdata on grant, and hold mem_addr, mem_wen and mem_wdata stable throughout BUSY.
REQ-024 SHALL drive mem_cen=1 only in I_BUSY and D_BUSY, with mem_wen=0 always in I_BUSY.
REQ-025 SHALL, on mem_ready in BUSY, capture mem_rdata into rdata, update last_grant, and go to DONE.
REQ-026 SHALL ignore mem_ready outside BUSY.
REQ-027 SHALL assert exactly the owner's ack in DONE for one cycle, then return to IDLE.
REQ-028 SHALL treat a request still high in the IDLE cycle after DONE as a new request; minimum occupancy is 3 cycles per transaction.
REQ-029 SHALL have a latency where req sampled at edge 0 gives mem_cen from cycle 1; mem_ready in cycle N gives ack in cycle N+1.
REQ-030 SHALL count BUSY cycles in an 8-bit counter cleared on grant; when the counter reaches TIMEOUT without mem_ready, go to DONE with err=1 and rdata=0.
REQ-031 SHALL give mem_ready in the same cycle the counter reaches TIMEOUT precedence, meaning no error.
REQ-032 SHALL leave request changes during BUSY without effect on the latched transaction.

Reset
REQ-033 SHALL, on rst, force asynchronously state=IDLE, last_grant=I, counter=0, rdata=0, i_ack=d_ack=err=0, mem_cen=mem_wen=0, mem_addr=mem_wdata=0.
REQ-034 SHALL, on rst asserted mid-transaction, drop the transaction with no ack after release; requesters reissue.

Structure
REQ-035 SHALL place the FSM state encoding, the owner encoding (I=0, D=1) and the counter width in a shared CPU package.
REQ-036 SHALL form mem_addr and mem_wdata from latched registers through the existing two-input 32-bit selector Mux2 instances, select=owner.

Verification
REQ-037 SHALL cover: i_req=1, i_addr=0x100, mem_ready in cycle 3 with mem_rdata=0xDEADBEEF -> mem_addr=0x100 in cycles 1-3, i_ack and rdata=0xDEADBEEF in cycle 4.
REQ-038 SHALL cover: i_req and d_req both high from reset -> D served first, then I, then alternating while both stay high.
REQ-039 SHALL cover: d_req, d_wen=1, d_addr=0x200, d_wdata=0x12345678 -> mem_wen=1, mem_wdata=0x12345678 held until mem_ready; d_ack=1, i_ack=0.
REQ-040 SHALL cover: TIMEOUT=4, mem_ready never high -> ack and err=1 in cycle 6, rdata=0; next request proceeds normally.
REQ-041 SHALL cover: rst pulsed during D_BUSY -> all outputs 0 immediately, no d_ack after release.
